// File: rtl/mem_pattern_tester_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_pattern_tester_if : control/status bundle of the RAM tester  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_pattern_tester_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              button;
  logic [1:0]        mode;
  logic              corrupt;
  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] led;
  logic              err;
  logic              ones_flag;
  logic              done;

  modport master (
    output button, mode, corrupt,
    input  state, addr, rd_data, led, err, ones_flag, done
  );

  modport slave (
    input  button, mode, corrupt,
    output state, addr, rd_data, led, err, ones_flag, done
  );
endinterface
`default_nettype wire

// File: rtl/mem_pattern_tester.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_pattern_tester : writes a pattern to an internal RAM, reads   |
// | it back and flags mismatches / all-ones words.                   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_pattern_tester #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DIV    = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mem_pattern_tester_if.slave bus
);
  localparam int                 c_DEPTH   = 2 ** ADDR_W;
  localparam int                 c_CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [ADDR_W-1:0]  c_LAST    = '1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_sync1, r_sync2, r_sync3;
  logic [1:0]          r_vld;
  logic                r_armed;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [1:0]          r_mode;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_cmp_addr;
  logic                r_cmp_pend;
  logic                r_last_issued;
  logic [DATA_W-1:0]   r_rd_data;
  logic [DATA_W-1:0]   r_ram_q;
  logic                r_err;
  logic                r_ones;
  logic [DATA_W-1:0]   r_mem [c_DEPTH];

  logic                w_start;
  logic                w_tick;
  logic                w_wr_en;
  logic                w_rd_en;
  logic [DATA_W-1:0]   w_wr_data;

  function automatic logic [DATA_W-1:0] f_pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w_lin;
    w_lin = DATA_W'(a);
    case (m)
      2'd0:    f_pattern = DATA_W'(1) << (32'(a) % DATA_W);
      2'd1:    f_pattern = w_lin;
      2'd2:    f_pattern = '1;
      default: f_pattern = ~w_lin;
    endcase
  endfunction

  // r_armed only sets once the synchronizer has seen button low after reset,
  // so a button held through reset release cannot look like a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_vld   <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_sync2) r_armed <= 1'b1;
    end
  end

  assign w_start   = r_armed & r_sync2 & ~r_sync3;
  assign w_tick    = (r_cnt == c_CNT_MAX);
  assign w_wr_en   = (r_state == S_WRITE) && w_tick;
  assign w_rd_en   = (r_state == S_READ) && w_tick && !r_last_issued;
  assign w_wr_data = f_pattern(r_mode, r_addr) ^ DATA_W'(bus.corrupt);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_addr] <= w_wr_data;
    if (w_rd_en) r_ram_q <= r_mem[r_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mode        <= 2'd0;
      r_addr        <= '0;
      r_cmp_addr    <= '0;
      r_cmp_pend    <= 1'b0;
      r_last_issued <= 1'b0;
      r_rd_data     <= '0;
      r_err         <= 1'b0;
      r_ones        <= 1'b0;
    end else begin
      r_cmp_pend <= w_rd_en;
      if (w_rd_en) r_cmp_addr <= r_addr;
      if (r_cmp_pend) begin
        r_rd_data <= r_ram_q;
        if (r_ram_q != f_pattern(r_mode, r_cmp_addr)) r_err <= 1'b1;
        if (&r_ram_q) r_ones <= 1'b1;
      end
      if (r_state == S_WRITE || r_state == S_READ)
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_mode        <= bus.mode;
            r_err         <= 1'b0;
            r_ones        <= 1'b0;
            r_addr        <= '0;
            r_last_issued <= 1'b0;
            r_cnt         <= '0;
            r_state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_tick) begin
            r_addr <= r_addr + 1'b1;
            if (r_addr == c_LAST) r_state <= S_READ;
          end
        end
        S_READ: begin
          if (w_rd_en) begin
            if (r_addr == c_LAST) r_last_issued <= 1'b1;
            else                  r_addr        <= r_addr + 1'b1;
          end
          // The last compare lands one cycle after the last read issue.
          if (r_cmp_pend && r_cmp_addr == c_LAST) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state     = r_state;
  assign bus.addr      = r_addr;
  assign bus.rd_data   = r_rd_data;
  assign bus.led       = ((r_state == S_READ || r_state == S_DONE) && r_ones) ? r_rd_data : '0;
  assign bus.err       = r_err;
  assign bus.ones_flag = r_ones;
  assign bus.done      = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_mem_pattern_tester.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_pattern_tester : directed + randomized checks of the tester |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_pattern_tester;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_fail;
  int   n_total;

  mem_pattern_tester_if #(.DATA_W(16), .ADDR_W(4)) ifa ();
  mem_pattern_tester_if #(.DATA_W(16), .ADDR_W(4)) ifb ();
  mem_pattern_tester_if #(.DATA_W(8),  .ADDR_W(5)) ifc ();

  mem_pattern_tester #(.DATA_W(16), .ADDR_W(4), .DIV(1)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mem_pattern_tester #(.DATA_W(16), .ADDR_W(4), .DIV(4)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  mem_pattern_tester #(.DATA_W(8),  .ADDR_W(5), .DIV(1)) u_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected RAM word straight from the pattern definitions.
  function automatic logic [63:0] pat(input int dw, input int m, input int a);
    logic [63:0] mask;
    mask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    case (m)
      0:       return 64'd1 << (a % dw);
      1:       return 64'(a) & mask;
      2:       return mask;
      default: return ~64'(a) & mask;
    endcase
  endfunction

  task automatic run_a(input int m, input int c);
    logic [63:0] stored;
    logic        exp_err;
    logic        exp_ones;
    ifa.mode    = 2'(m);
    ifa.corrupt = c[0];
    ifa.button  = 1'b1;
    repeat (3) step();
    ifa.button = 1'b0;
    ifa.mode   = 2'($urandom);
    chk("a_write_state", ifa.state, 64'd1);
    chk("a_write_addr",  ifa.addr,  64'd0);
    chk("a_err_clear",   ifa.err,   64'd0);
    chk("a_ones_clear",  ifa.ones_flag, 64'd0);
    repeat (16) step();
    chk("a_read_state", ifa.state, 64'd2);
    chk("a_read_addr",  ifa.addr,  64'd0);
    step();
    exp_err  = 1'b0;
    exp_ones = 1'b0;
    for (int a = 0; a < 16; a++) begin
      step();
      stored   = pat(16, m, a) ^ 64'(c[0]);
      exp_err  = exp_err | (stored != pat(16, m, a));
      exp_ones = exp_ones | (stored == 64'hFFFF);
      chk($sformatf("a_rd%0d_m%0d_c%0d", a, m, c), ifa.rd_data, stored);
      chk($sformatf("a_err%0d", a),  ifa.err,       64'(exp_err));
      chk($sformatf("a_ones%0d", a), ifa.ones_flag, 64'(exp_ones));
      chk($sformatf("a_led%0d", a),  ifa.led,       exp_ones ? stored : 64'd0);
      chk($sformatf("a_state%0d", a), ifa.state,    (a == 15) ? 64'd3 : 64'd2);
    end
    chk("a_done", ifa.done, 64'd1);
    chk("a_done_addr", ifa.addr, 64'd15);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst = 1'b0;
    ifa.button = 1'b0; ifa.mode = 2'd0; ifa.corrupt = 1'b0;
    ifb.button = 1'b0; ifb.mode = 2'd0; ifb.corrupt = 1'b0;
    ifc.button = 1'b0; ifc.mode = 2'd0; ifc.corrupt = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_state", ifa.state, 64'd0);
    chk("rst_addr",  ifa.addr,  64'd0);
    chk("rst_rd",    ifa.rd_data, 64'd0);
    chk("rst_led",   ifa.led,   64'd0);
    chk("rst_err",   ifa.err,   64'd0);
    chk("rst_ones",  ifa.ones_flag, 64'd0);
    chk("rst_done",  ifa.done,  64'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();

    run_a(1, 0);
    run_a(2, 0);
    run_a(0, 1);
    for (int i = 0; i < 4; i++) run_a(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));

    // Reset in the middle of WRITE with button held high through release.
    ifa.mode   = 2'd2;
    ifa.button = 1'b1;
    repeat (3) step();
    repeat (7) step();
    chk("mid_state", ifa.state, 64'd1);
    chk("mid_addr",  ifa.addr,  64'd7);
    rst = 1'b1;
    #1;
    chk("mid_rst_state", ifa.state, 64'd0);
    chk("mid_rst_addr",  ifa.addr,  64'd0);
    chk("mid_rst_rd",    ifa.rd_data, 64'd0);
    chk("mid_rst_led",   ifa.led,   64'd0);
    chk("mid_rst_err",   ifa.err,   64'd0);
    chk("mid_rst_ones",  ifa.ones_flag, 64'd0);
    chk("mid_rst_done",  ifa.done,  64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("held_idle%0d", i), ifa.state, 64'd0);
    end
    ifa.button = 1'b0;
    repeat (3) step();
    chk("idle_after_release", ifa.state, 64'd0);
    run_a(int'($urandom_range(0, 3)), 0);

    // DIV=4: one address step every four cycles; a button pulse in READ is ignored.
    ifb.mode   = 2'd1;
    ifb.button = 1'b1;
    repeat (3) step();
    ifb.button = 1'b0;
    for (int n = 0; n < 64; n++) begin
      chk($sformatf("b_wstate%0d", n), ifb.state, 64'd1);
      chk($sformatf("b_waddr%0d", n),  ifb.addr,  64'(n / 4));
      step();
    end
    for (int n = 0; n < 64; n++) begin
      chk($sformatf("b_rstate%0d", n), ifb.state, 64'd2);
      chk($sformatf("b_raddr%0d", n),  ifb.addr,  64'(n / 4));
      if (n == 8)  ifb.button = 1'b1;
      if (n == 12) ifb.button = 1'b0;
      step();
    end
    chk("b_last_state", ifb.state, 64'd2);
    chk("b_last_addr",  ifb.addr,  64'd15);
    step();
    chk("b_done", ifb.done, 64'd1);
    chk("b_err",  ifb.err,  64'd0);
    chk("b_rd15", ifb.rd_data, pat(16, 1, 15));

    // DATA_W=8, ADDR_W=5, inverted-address pattern.
    ifc.mode   = 2'd3;
    ifc.button = 1'b1;
    repeat (3) step();
    ifc.button = 1'b0;
    chk("c_write_state", ifc.state, 64'd1);
    repeat (32) step();
    chk("c_read_state", ifc.state, 64'd2);
    step();
    for (int a = 0; a < 32; a++) begin
      step();
      chk($sformatf("c_rd%0d", a), ifc.rd_data, pat(8, 3, a));
      chk($sformatf("c_ones%0d", a), ifc.ones_flag, 64'd1);
      chk($sformatf("c_err%0d", a), ifc.err, 64'd0);
      if (a == 20) chk("c_rd20_const", ifc.rd_data, 64'hEB);
    end
    chk("c_done", ifc.done, 64'd1);
    chk("c_led",  ifc.led,  pat(8, 3, 31));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_pattern_tester.md
MEM_PATTERN_TESTER -- requirements
Module: mem_pattern_tester

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning RAM word width in bits (4..64).
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width, with DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter DIV, default 4, meaning clock cycles per step tick (>=1).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 The block SHALL have port button, input, 1, meaning raw start request (asynchronous to clk).
REQ-007 The block SHALL have port mode, input, 2, meaning pattern select, latched at start.
REQ-008 The block SHALL have port corrupt, input, 1, meaning test hook: when high, invert bit 0 of each word written.
REQ-009 The block SHALL have port state, output, 2, meaning 0 IDLE, 1 WRITE, 2 READ, 3 DONE.
REQ-010 The block SHALL have port addr, output, ADDR_W, meaning current RAM address.
REQ-011 The block SHALL have port rd_data, output, DATA_W, meaning last word read.
REQ-012 The block SHALL have port led, output, DATA_W, meaning display word.
REQ-013 The block SHALL have ports err, ones_flag and done, each output, 1, meaning sticky mismatch, sticky all-ones-seen, and DONE-state indicator respectively.

Function
REQ-014 The block SHALL pass button through a 2-flop synchronizer and generate start as a one-cycle pulse on its rising edge, so start asserts 3 cycles after button rises.
REQ-015 The block SHALL contain an internal synchronous single-port RAM of DEPTH x DATA_W with 1-cycle read latency; contents are undefined after reset.
REQ-016 The step tick SHALL come from a counter 0..DIV-1 that pulses when at DIV-1, runs only in WRITE/READ, and clears to 0 on every state change; DIV=1 ticks every cycle.
REQ-017 The pattern SHALL be selected by mode (latched on start): 0 = walking one, 1 << (addr mod DATA_W); 1 = addr zero-extended/truncated to DATA_W; 2 = all ones; 3 = bitwise NOT of the mode-1 value.
REQ-018 In IDLE, start SHALL latch mode, clear err and ones_flag, set addr=0 and enter WRITE.
REQ-019 In WRITE, each tick SHALL write pattern(addr), with bit 0 inverted if corrupt, to addr; at addr=DEPTH-1 the write SHALL complete, addr wraps to 0 and the state goes to READ, otherwise addr increments.
REQ-020 In READ, each tick SHALL issue a read of addr; on the following cycle rd_data updates and the word is compared with pattern(issued addr), mode-1 etc. computed without corrupt.
REQ-021 A read compare mismatch SHALL set err; a word equal to all ones SHALL set ones_flag; both flags are sticky until the next start or reset.
REQ-022 The READ state SHALL transition to DONE on the cycle the compare of address DEPTH-1 occurs, i.e. one cycle after the last read issue; addr holds DEPTH-1 in DONE.
REQ-023 In DONE, done SHALL be 1, and start SHALL restart exactly as from IDLE; start in WRITE or READ SHALL be ignored.
REQ-024 The led output SHALL be rd_data when state is READ or DONE and ones_flag=1, and 0 otherwise.
REQ-025 A mode change after start SHALL have no effect until the next start.

Reset
REQ-026 While rst is high, the block SHALL force state=IDLE, addr=0, rd_data=0, led=0, err=0, ones_flag=0, done=0, tick counter=0 and synchronizer flops=0, immediately and without a clock.
REQ-027 Reset asserted mid-WRITE or mid-READ SHALL abort the operation; after release the block SHALL wait in IDLE for a new rising edge of button, and a button held high through release SHALL NOT start a run.

Verification
REQ-028 The bench SHALL check: defaults, DIV=1, mode=1, button pulse -> WRITE of 16 words, READ, DONE 3+16+16+1 cycles after button rise; err=0, ones_flag=0, led=0.
REQ-029 The bench SHALL check: mode=2 -> every read returns 16'hFFFF, ones_flag=1, err=0, and led=16'hFFFF in DONE.
REQ-030 The bench SHALL check: mode=0, corrupt=1 throughout WRITE -> address 0 reads 16'h0000 vs expected 16'h0001, err=1 after the first compare, and the run still reaches DONE.
REQ-031 The bench SHALL check: DIV=4 -> addr advances exactly every 4 cycles, and a button pulse during READ leaves state and addr unaffected.
REQ-032 The bench SHALL check: rst pulse at WRITE addr=7 -> all outputs are 0 within the same cycle, state=IDLE, and the block stays in IDLE until a new button edge.
REQ-033 The bench SHALL check: mode=3, ADDR_W=5, DATA_W=8 -> expected word at addr 20 is 8'hEB, err=0, and ones_flag=1 from addr 0 (8'hFF).
